// File: rtl/persiana_pkg.sv
`default_nettype none
// ============================================================================
// Module      : persiana_pkg
// Description : Shared types and defaults for the blind actuator/emulator.
//               estado_t    - motor FSM state encoding
//               POS_W_DEF   - default position counter width
//               SENSOR_W    - width of each end/middle sensor line
//               es_movim()  - true for the two motor-running states
// Revision    : 1.0 - initial release
// ============================================================================
package persiana_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SUBIENDO = 3'd1,
    BAJANDO  = 3'd2,
    PAUSA    = 3'd3,
    FALLA    = 3'd4
  } estado_t;

  localparam int POS_W_DEF = 8;
  localparam int SENSOR_W  = 1;

  function automatic logic es_movim(input estado_t e);
    return (e == SUBIENDO) || (e == BAJANDO);
  endfunction

endpackage
`default_nettype wire

// File: rtl/persiana_paso_div.sv
`default_nettype none
// ============================================================================
// Module      : persiana_paso_div
// Description : Divides the timebase tick down to one position step every
//               TICKS_PER_STEP ticks. paso is a combinational one-cycle
//               strobe on the tick that completes a step.
// Ports       : clk, reseteo (async, active-high), tick (timebase strobe),
//               clr (hold counter at 0, suppress paso), paso (step strobe)
// Revision    : 1.0 - initial release
// ============================================================================
module persiana_paso_div #(
  parameter int TICKS_PER_STEP = 4
) (
  input  logic clk,
  input  logic reseteo,
  input  logic tick,
  input  logic clr,
  output logic paso
);

  localparam int CNT_W = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICKS_PER_STEP - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    paso  = 1'b0;
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (tick) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        paso  = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reseteo) begin
    if (reseteo) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule
`default_nettype wire

// File: rtl/persiana_actuador.sv
`default_nettype none
// ============================================================================
// Module      : persiana_actuador
// Description : Plant model of the blind motor and its position sensors.
//               Integrates position from subir/bajar commands, inserts a
//               dead time on direction reversal and flags contradictory
//               commands as a fault.
// Ports       : clk, reseteo (async, active-high), tick (timebase strobe),
//               subir/bajar (motor commands), Ssup/Smed/Sinf (sensors),
//               pos (position, 0=closed), moviendo, falla,
//               fin_carrera (only with PERSIANA_ENDSTOP_STOP_EN)
// Config      : `define PERSIANA_ENDSTOP_STOP_EN to stop the motor at the
//               end-stops and pulse fin_carrera; otherwise the motor stalls
//               in its running state at saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module persiana_actuador
  import persiana_pkg::*;
#(
  parameter int POS_W          = POS_W_DEF,
  parameter int POS_MAX        = 200,
  parameter int POS_MED        = 100,
  parameter int MED_WIN        = 2,
  parameter int TICKS_PER_STEP = 4,
  parameter int REV_DELAY      = 3
) (
  input  logic             clk,
  input  logic             reseteo,
  input  logic             tick,
  input  logic             subir,
  input  logic             bajar,
  output logic             Ssup,
  output logic             Smed,
  output logic             Sinf,
  output logic [POS_W-1:0] pos,
  output logic             moviendo,
  output logic             falla
`ifdef PERSIANA_ENDSTOP_STOP_EN
  ,
  output logic             fin_carrera
`endif
);

  localparam int DT_W = $clog2(REV_DELAY + 1);
  localparam logic [DT_W-1:0]         DT_LOAD = DT_W'(REV_DELAY);
  localparam logic [POS_W-1:0]        P_MAX   = POS_W'(POS_MAX);
  localparam logic [POS_W-1:0]        P_MED   = POS_W'(POS_MED);
  // One bit wider and signed so the window test cannot wrap at 0 or POS_MAX
  localparam logic signed [POS_W:0]   WIN_P   = (POS_W+1)'(MED_WIN);
  localparam logic signed [POS_W:0]   WIN_N   = -WIN_P;

  estado_t state_q, state_d, state_base;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [DT_W-1:0]  dt_q, dt_d;
  logic             dir_up_q, dir_up_d;   // target direction while in PAUSA
  logic             ssup_q, smed_q, sinf_q, mov_q, falla_q;
  logic             step_clr, paso;
  logic             up_only, down_only, none;
  logic signed [POS_W:0] med_dif;

  logic             lock_up_q, lock_dn_q;

  assign up_only   = subir & ~bajar;
  assign down_only = bajar & ~subir;
  assign none      = ~subir & ~bajar;

  // Command-driven transitions; end-stop handling is layered on afterwards
  // so the step enable never depends on its own result.
  always_comb begin
    state_base = state_q;
    dt_d       = '0;
    dir_up_d   = dir_up_q;
    if (subir & bajar) begin
      state_base = FALLA;
    end else if (state_q == FALLA) begin
      if (none) state_base = IDLE;
    end else if (none) begin
      state_base = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (up_only && !lock_up_q)        state_base = SUBIENDO;
          else if (down_only && !lock_dn_q) state_base = BAJANDO;
        end
        SUBIENDO: begin
          if (down_only) begin
            state_base = PAUSA;
            dir_up_d   = 1'b0;
            dt_d       = DT_LOAD;
          end
        end
        BAJANDO: begin
          if (up_only) begin
            state_base = PAUSA;
            dir_up_d   = 1'b1;
            dt_d       = DT_LOAD;
          end
        end
        PAUSA: begin
          if (up_only != dir_up_q) begin
            // Command flipped back: restart the dead time toward it
            dir_up_d = up_only;
            dt_d     = DT_LOAD;
          end else if (tick) begin
            if (dt_q <= DT_W'(1)) state_base = dir_up_q ? SUBIENDO : BAJANDO;
            else                  dt_d = dt_q - DT_W'(1);
          end else begin
            dt_d = dt_q;
          end
        end
        default: state_base = IDLE;
      endcase
    end
  end

  assign step_clr = !(es_movim(state_q) && (state_base == state_q));

  persiana_paso_div #(
    .TICKS_PER_STEP(TICKS_PER_STEP)
  ) u_paso_div (
    .clk    (clk),
    .reseteo(reseteo),
    .tick   (tick),
    .clr    (step_clr),
    .paso   (paso)
  );

  always_comb begin
    pos_d = pos_q;
    if (paso) begin
      if (state_q == SUBIENDO && pos_q < P_MAX)       pos_d = pos_q + POS_W'(1);
      else if (state_q == BAJANDO && pos_q != '0)     pos_d = pos_q - POS_W'(1);
    end
  end

`ifdef PERSIANA_ENDSTOP_STOP_EN
  logic ev_up, ev_dn, fin_q;
  // A step that lands on (or pushes against) an end-stop stops the motor
  assign ev_up = paso && (state_q == SUBIENDO) && (pos_d == P_MAX);
  assign ev_dn = paso && (state_q == BAJANDO)  && (pos_d == '0);
  assign state_d = (ev_up || ev_dn) ? IDLE : state_base;

  // Lock blocks restarting in the same direction until the command changes
  always_ff @(posedge clk or posedge reseteo) begin
    if (reseteo) begin
      lock_up_q <= 1'b0;
      lock_dn_q <= 1'b0;
      fin_q     <= 1'b0;
    end else begin
      lock_up_q <= ev_up | (lock_up_q & up_only);
      lock_dn_q <= ev_dn | (lock_dn_q & down_only);
      fin_q     <= ev_up | ev_dn;
    end
  end
  assign fin_carrera = fin_q;
`else
  assign state_d   = state_base;
  assign lock_up_q = 1'b0;
  assign lock_dn_q = 1'b0;
`endif

  assign med_dif = $signed({1'b0, pos_d}) - $signed({1'b0, P_MED});

  always_ff @(posedge clk or posedge reseteo) begin
    if (reseteo) begin
      state_q  <= IDLE;
      pos_q    <= '0;
      dt_q     <= '0;
      dir_up_q <= 1'b0;
      ssup_q   <= 1'b0;
      smed_q   <= 1'b0;
      sinf_q   <= 1'b1;
      mov_q    <= 1'b0;
      falla_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      dt_q     <= dt_d;
      dir_up_q <= dir_up_d;
      ssup_q   <= (pos_d == P_MAX);
      smed_q   <= (med_dif >= WIN_N) && (med_dif <= WIN_P);
      sinf_q   <= (pos_d == '0);
      mov_q    <= es_movim(state_d);
      falla_q  <= (state_d == FALLA);
    end
  end

  assign Ssup     = ssup_q;
  assign Smed     = smed_q;
  assign Sinf     = sinf_q;
  assign pos      = pos_q;
  assign moviendo = mov_q;
  assign falla    = falla_q;

endmodule
`default_nettype wire

// File: doc/persiana_actuador.md
Name: persiana_actuador

Overview:
Behavioural model and driver of the blind motor and its position sensors: the plant side of the blind-control loop.
- Consumes the controller's subir/bajar motor commands.
- Integrates blind position in discrete steps.
- Produces the Ssup/Smed/Sinf sensor signals that the controller FSM reads.
- Used in closed-loop simulation and as an on-board emulator when no real blind is fitted.

Parameters:
POS_W, 8, width of position counter
POS_MAX, 200, fully-open position (Ssup point); must be < 2**POS_W
POS_MED, 100, half-open position (Smed centre)
MED_WIN, 2, Smed asserted while |pos-POS_MED| <= MED_WIN
TICKS_PER_STEP, 4, tick pulses per one-step position change (>=1)
REV_DELAY, 3, dead-time ticks on direction reversal (>=1)

Ports:
clk  in  1  system clock
reseteo  in  1  asynchronous, active-high reset
tick  in  1  one-cycle timebase strobe from the prescaler
subir  in  1  motor-up command
bajar  in  1  motor-down command
Ssup  out  1  top sensor, pos==POS_MAX
Smed  out  1  middle sensor window
Sinf  out  1  bottom sensor, pos==0
pos  out  POS_W  current position, 0=closed
moviendo  out  1  high in SUBIENDO/BAJANDO
falla  out  1  high in FALLA

Behaviour:
Reset, asynchronous, effective immediately:
- state=IDLE, pos=0, step counter=0, dead-time counter=0.
- Sinf=1; Ssup=0, Smed=0, moviendo=0, falla=0.
Registered outputs:
- Sensors are registered and computed from the next-state pos, so they change on the same edge as pos (0 cycles of lag relative to pos).
- moviendo and falla are registered from the next state.
States IDLE, SUBIENDO, BAJANDO, PAUSA, FALLA; transitions evaluated every clk, priority top-down:
- subir&bajar, any state -> FALLA. Step and dead-time counters cleared. pos holds.
- FALLA -> IDLE only on the first cycle with subir=bajar=0. Sticky while either command is high.
- Neither command -> IDLE immediately; step counter cleared.
- IDLE + subir -> SUBIENDO; IDLE + bajar -> BAJANDO.
- SUBIENDO + bajar only, or BAJANDO + subir only -> PAUSA:
  - dead-time counter loaded with REV_DELAY and decremented on each tick.
  - At 0, enter the commanded direction.
  - If the command drops to none during PAUSA -> IDLE.
  - If the command flips back during PAUSA, PAUSA restarts with the new target.
Stepping, SUBIENDO/BAJANDO:
- Step counter increments on tick.
- On the tick where it reaches TICKS_PER_STEP-1, it wraps to 0 and pos moves ±1.
- Step counter holds when tick=0.
- Step counter resets to 0 on any state change.
End-stops:
- pos saturates at POS_MAX (up) and 0 (down); it never wraps.
- Without the optional feature, state remains SUBIENDO/BAJANDO at saturation (moviendo=1, motor stalled).
Arithmetic:
- Smed comparison uses POS_W+1 signed difference, with no overflow at pos=0 or POS_MAX.
- Sinf and Ssup are mutually exclusive; Smed may coexist with neither at boundaries only if parameters overlap. Parameter check: POS_MED±MED_WIN must lie within 1..POS_MAX-1.

Optional Feature:
Macro PERSIANA_ENDSTOP_STOP_EN.
- Defined: on reaching an end-stop (pos becomes POS_MAX in SUBIENDO, or 0 in BAJANDO), state -> IDLE on the same edge. The FSM stays in IDLE while the same command persists; a new move requires the opposite command, or the command dropping and reasserting. An extra output fin_carrera pulses 1 cycle on that edge.
- Undefined: the stalled-motor behaviour above applies and port fin_carrera is absent.

Decomposition:
Package persiana_pkg holds:
- enum estado_t {IDLE, SUBIENDO, BAJANDO, PAUSA, FALLA}
- default localparams for POS_W and the sensor widths.
One sub-module, persiana_paso_div: tick-to-step divider with clear input, producing a one-cycle paso strobe. The parent owns the state machine and position register.

Test Plan:
All scenarios use default parameters and tick high every cycle.
1. Reset then subir=1 for 800 cycles -> pos reaches 200, Ssup=1 at the cycle after the 800th tick. Smed=1 exactly for pos 98..102. Sinf drops when pos=1, 4 cycles after the start of motion.
2. From pos=200 with subir held 20 more cycles -> pos stays 200, moviendo=1. With PERSIANA_ENDSTOP_STOP_EN: IDLE, moviendo=0, a single fin_carrera pulse.
3. Moving up at pos=50, switch to bajar only -> 3 cycles PAUSA (moviendo=0, pos=50), then BAJANDO; pos=49 after 4 further ticks.
4. subir and bajar both high during SUBIENDO -> falla=1 next edge, pos frozen. Drop bajar only -> stays FALLA. Drop both -> IDLE one cycle later.
5. Toggle tick at 1/10 duty during BAJANDO from pos=10 -> one step per 40 cycles. Pos reaches 0, Sinf=1, no underflow.
6. Assert reseteo mid-SUBIENDO at pos=120 asynchronously between edges -> pos=0, Sinf=1, outputs low immediately. Resume with subir after release -> motion restarts from 0.
